// File: rtl/perf_trace_pkg.sv
// perf_trace_pkg: shared types and constants for the store-trace checker.
//   trace_state_e : run-control FSM states (IDLE, RUN, DONE)
//   ERR_W         : width of the saturating error counter
//   sat_add_err   : saturating add used for the error counter
package perf_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } trace_state_e;

    localparam int ERR_W = 16;

    // Adds an arbitrary non-negative increment, clamping at all-ones.
    function automatic logic [ERR_W-1:0] sat_add_err(input logic [ERR_W-1:0] base,
                                                     input int unsigned       inc);
        logic [63:0] sum;
        sum = 64'(base) + 64'(inc);
        if (|sum[63:ERR_W]) return '1;
        return sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: expected-store FIFO, one push and up to NCH pops per cycle.
//   clk, reset     : clock, asynchronous active-low reset
//   push_i/_data_i : write one entry (ignored while full)
//   pop_cnt_i      : number of head entries consumed this cycle (<= count)
//   flush_i        : discard all contents (wins over push/pop)
//   peek_o         : the NCH oldest entries, entry k at bits [k*W +: W]
//   count_o        : current occupancy
//   full_o         : occupancy == DEPTH
module trace_fifo #(
    parameter int NCH   = 2,
    parameter int DEPTH = 64,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic [$clog2(DEPTH):0] pop_cnt_i,
    input  logic                   flush_i,
    output logic [NCH*W-1:0]       peek_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign push_ok = push_i & ~full_o;
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            rd_ptr_q <= rd_ptr_q + PW'(pop_cnt_i);
            count_q  <= count_q + (PW+1)'(push_ok) - pop_cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_peek
        assign peek_o[k*W +: W] = mem_q[rd_ptr_q + PW'(k)];
    end

endmodule

// File: rtl/perf_trace_checker.sv
// perf_trace_checker: compares CPU store traffic against a preloaded list of
// expected stores and counts cycles, retired instructions and errors.
//   clk, reset                 : clock, asynchronous active-low reset
//   start                      : pulse that begins (or resumes) a run
//   finish_pc, pc              : run ends when pc reaches finish_pc
//   stallD, flushD             : decode-stage stall/flush for retire counting
//   st_valid/st_addr/st_data   : NCH store channels, channel 0 oldest
//   exp_valid/exp_ready/exp_*  : expected-store load port
//   cpu_halt, done, pass       : run status
//   cycle_cnt, instr_cnt       : saturating RUN-cycle / retire counters
//   err_cnt                    : saturating error count
//   mm_valid/mm_addr/mm_data   : first offending actual store
//   dbg_state                  : FSM state (IDLE=0, RUN=1, DONE=2)
// Build option: define TRACE_STOP_ON_ERROR_EN to end the run on the first error.
module perf_trace_checker
    import perf_trace_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 64,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     finish_pc,
    input  logic [AW-1:0]     pc,
    input  logic              stallD,
    input  logic              flushD,
    input  logic [NCH-1:0]    st_valid,
    input  logic [NCH*AW-1:0] st_addr,
    input  logic [NCH*DW-1:0] st_data,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [AW-1:0]     exp_addr,
    input  logic [DW-1:0]     exp_data,
    output logic              cpu_halt,
    output logic              done,
    output logic              pass,
    output logic [CW-1:0]     cycle_cnt,
    output logic [CW-1:0]     instr_cnt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              mm_valid,
    output logic [AW-1:0]     mm_addr,
    output logic [DW-1:0]     mm_data,
    output logic [1:0]        dbg_state
);

    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int EW   = AW + DW;

    trace_state_e     state_q, state_d;
    logic [CW-1:0]    cycle_q, instr_q;
    logic [ERR_W-1:0] err_q;
    logic             mm_valid_q;
    logic [AW-1:0]    mm_addr_q;
    logic [DW-1:0]    mm_data_q;

    logic [NCH*EW-1:0] fifo_peek;
    logic [CNTW-1:0]   fifo_count;
    logic              fifo_full;
    logic              push;
    logic              checking;
    logic              go_done;
    logic              bad;
    logic              hit;
    logic [AW-1:0]     hit_addr;
    logic [DW-1:0]     hit_data;
    int unsigned       n_pop, n_bad, n_miss, err_inc;

    // Expected-store handshake: an entry transfers on a cycle where
    // exp_valid and exp_ready are both high; exp_ready is simply "not full"
    // and does not depend on exp_valid or on pops in the same cycle.
    assign exp_ready = ~fifo_full;
    assign push      = exp_valid & ~fifo_full;

    assign cpu_halt  = (pc == finish_pc) || (state_q == ST_DONE);
    assign checking  = (state_q == ST_RUN) && !cpu_halt;

    // Valid channels consume consecutive FIFO heads in channel order; a valid
    // channel with no head left is an unexpected store and pops nothing.
    always_comb begin
        n_pop    = 0;
        n_bad    = 0;
        bad      = 1'b0;
        hit      = 1'b0;
        hit_addr = '0;
        hit_data = '0;
        for (int i = 0; i < NCH; i++) begin
            bad = 1'b0;
            if (checking && st_valid[i]) begin
                if (n_pop < 32'(fifo_count)) begin
                    bad   = (fifo_peek[n_pop*EW +: EW] != {st_addr[i*AW +: AW], st_data[i*DW +: DW]});
                    n_pop = n_pop + 1;
                end else begin
                    bad = 1'b1;
                end
            end
            if (bad) begin
                n_bad = n_bad + 1;
                if (!hit) begin
                    hit      = 1'b1;
                    hit_addr = st_addr[i*AW +: AW];
                    hit_data = st_data[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        go_done = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (pc == finish_pc) go_done = 1'b1;
`ifdef TRACE_STOP_ON_ERROR_EN
                if (n_bad != 0) go_done = 1'b1;
`endif
            end
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        if (go_done) state_d = ST_DONE;
        // Whatever is still queued at the end of a run (including a push
        // landing in the same cycle) was never stored by the CPU.
        n_miss  = go_done ? (32'(fifo_count) + 32'(push) - n_pop) : 32'd0;
        err_inc = n_bad + n_miss;
    end

    trace_fifo #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({exp_addr, exp_data}),
        .pop_cnt_i   (CNTW'(n_pop)),
        .flush_i     (go_done),
        .peek_o      (fifo_peek),
        .count_o     (fifo_count),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cycle_q    <= '0;
            instr_q    <= '0;
            err_q      <= '0;
            mm_valid_q <= 1'b0;
            mm_addr_q  <= '0;
            mm_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_RUN) begin
                if (cycle_q != '1) cycle_q <= cycle_q + CW'(1);
                if (!stallD && !flushD && instr_q != '1) instr_q <= instr_q + CW'(1);
            end
            err_q <= sat_add_err(err_q, err_inc);
            if (!mm_valid_q && hit) begin
                mm_valid_q <= 1'b1;
                mm_addr_q  <= hit_addr;
                mm_data_q  <= hit_data;
            end
        end
    end

    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == '0);
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign err_cnt   = err_q;
    assign mm_valid  = mm_valid_q;
    assign mm_addr   = mm_addr_q;
    assign mm_data   = mm_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_perf_trace_checker.sv
module tb_perf_trace_checker;

    localparam int NCH   = 2;
    localparam int DEPTH = 64;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 32;
`ifdef TRACE_STOP_ON_ERROR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    localparam logic [AW-1:0] FIN = 32'h0000_FFF0;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start, stallD, flushD, exp_valid;
    logic [AW-1:0]     finish_pc, pc, exp_addr;
    logic [DW-1:0]     exp_data;
    logic [NCH-1:0]    st_valid;
    logic [NCH*AW-1:0] st_addr;
    logic [NCH*DW-1:0] st_data;
    logic              exp_ready, cpu_halt, done, pass, mm_valid;
    logic [CW-1:0]     cycle_cnt, instr_cnt;
    logic [15:0]       err_cnt;
    logic [AW-1:0]     mm_addr;
    logic [DW-1:0]     mm_data;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    perf_trace_checker #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .finish_pc(finish_pc), .pc(pc),
        .stallD(stallD), .flushD(flushD), .st_valid(st_valid), .st_addr(st_addr),
        .st_data(st_data), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_addr(exp_addr), .exp_data(exp_data), .cpu_halt(cpu_halt), .done(done),
        .pass(pass), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .err_cnt(err_cnt),
        .mm_valid(mm_valid), .mm_addr(mm_addr), .mm_data(mm_data), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    logic [63:0] m_q[$];
    int          m_state;  // 0 idle, 1 run, 2 done
    longint      m_cyc, m_ins, m_err;
    bit          m_mmv;
    logic [31:0] m_mma, m_mmd;

    task automatic model_reset();
        m_q.delete();
        m_state = 0; m_cyc = 0; m_ins = 0; m_err = 0;
        m_mmv = 1'b0; m_mma = '0; m_mmd = '0;
    endtask

    task automatic model_step();
        bit          halt, ready, bad;
        int          nerr;
        logic [63:0] act, e;
        halt  = (pc == FIN) || (m_state == 2);
        ready = (m_q.size() < DEPTH);
        nerr  = 0;
        if (m_state == 1 && !halt) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (st_valid[ch]) begin
                    act = {st_addr[ch*AW +: AW], st_data[ch*DW +: DW]};
                    if (m_q.size() > 0) begin
                        e   = m_q.pop_front();
                        bad = (e != act);
                    end else begin
                        bad = 1'b1;
                    end
                    if (bad) begin
                        nerr++;
                        if (!m_mmv) begin
                            m_mmv = 1'b1;
                            m_mma = act[63:32];
                            m_mmd = act[31:0];
                        end
                    end
                end
            end
        end
        if (exp_valid && ready) m_q.push_back({exp_addr, exp_data});
        if (m_state == 1) begin
            m_cyc++;
            if (!stallD && !flushD) m_ins++;
        end
        case (m_state)
            0: if (start) m_state = 1;
            1: if (pc == FIN || (STOP && nerr > 0)) begin
                   nerr += m_q.size();
                   m_q.delete();
                   m_state = 2;
               end
            default: if (start) m_state = 1;
        endcase
        m_err = m_err + nerr;
        if (m_err > 65535) m_err = 65535;
    endtask

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        start = 1'b0; stallD = 1'b0; flushD = 1'b0; exp_valid = 1'b0;
        exp_addr = '0; exp_data = '0; pc = '0; finish_pc = FIN;
        st_valid = '0; st_addr = '0; st_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_valid = 1'b1; exp_addr = a; exp_data = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic run_cyc(input logic [1:0] sv, input logic [31:0] a0, d0, a1, d1,
                           input logic [31:0] p);
        pc = p; st_valid = sv; st_addr = {a1, a0}; st_data = {d1, d0};
        tick();
        st_valid = '0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_state"}, 64'(dbg_state), 64'd0);
        chk({tag, "_err"}, 64'(err_cnt), 64'd0);
        chk({tag, "_cyc"}, 64'(cycle_cnt), 64'd0);
        chk({tag, "_ins"}, 64'(instr_cnt), 64'd0);
        chk({tag, "_flags"}, {60'd0, done, pass, mm_valid, cpu_halt}, 64'd0);
        chk({tag, "_mm"}, {mm_addr, mm_data}, 64'd0);
        chk({tag, "_ready"}, 64'(exp_ready), 64'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] ea, ed;
        logic [1:0]  sv;
        logic [31:0] a0, d0, a1, d1;
        logic [1:0]  e_state;
        logic [15:0] e_err;
        logic [31:0] e_cyc;
        logic        e_pass, e_mmv;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [31:0] p, input logic ev,
                                input logic [31:0] ea, ed, input logic [1:0] sv,
                                input logic [31:0] a0, d0, a1, d1, input logic [1:0] es,
                                input logic [15:0] ee, input logic [31:0] ec,
                                input logic ep, em);
        vec_t v;
        v.start = s; v.pc = p; v.ev = ev; v.ea = ea; v.ed = ed; v.sv = sv;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.e_state = es; v.e_err = ee; v.e_cyc = ec; v.e_pass = ep; v.e_mmv = em;
        return v;
    endfunction

    vec_t vecs[12];

    // ---------------- stimulus ----------------
    initial begin
        string nm;
        vecs[0]  = mk(0, 32'h0,  1, 32'h0,  32'h5,  2'b00, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 32'h0,  1, 32'h4,  32'h6,  2'b00, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 32'h0,  0, 0, 0,           2'b00, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 32'h4,  0, 0, 0,           2'b01, 32'h0, 32'h5, 0, 0, 2'd1, 0, 1, 0, 0);
        vecs[4]  = mk(0, 32'h8,  0, 0, 0,           2'b01, 32'h4, 32'h6, 0, 0, 2'd1, 0, 2, 0, 0);
        vecs[5]  = mk(0, 32'hC,  1, 32'h8,  32'h1,  2'b00, 0, 0, 0, 0, 2'd1, 0, 3, 0, 0);
        vecs[6]  = mk(0, 32'h10, 1, 32'hC,  32'h2,  2'b00, 0, 0, 0, 0, 2'd1, 0, 4, 0, 0);
        vecs[7]  = mk(0, 32'h14, 0, 0, 0,           2'b11, 32'h8, 32'h1, 32'hC, 32'h2, 2'd1, 0, 5, 0, 0);
        vecs[8]  = mk(0, FIN,    0, 0, 0,           2'b00, 0, 0, 0, 0, 2'd2, 0, 6, 1, 0);
        vecs[9]  = mk(1, 32'h0,  1, 32'h10, 32'hAA, 2'b00, 0, 0, 0, 0, 2'd1, 0, 6, 0, 0);
        vecs[10] = mk(0, 32'h4,  0, 0, 0,           2'b01, 32'h10, 32'hAB, 0, 0, STOP ? 2'd2 : 2'd1, 1, 7, 0, 1);
        vecs[11] = mk(0, FIN,    0, 0, 0,           2'b00, 0, 0, 0, 0, 2'd2, 1, STOP ? 7 : 8, 0, 1);

        do_reset();
        check_cleared("reset");

        // basic match, dual-channel match, single mismatch
        for (int r = 0; r < 12; r++) begin
            start = vecs[r].start; pc = vecs[r].pc;
            exp_valid = vecs[r].ev; exp_addr = vecs[r].ea; exp_data = vecs[r].ed;
            st_valid = vecs[r].sv; st_addr = {vecs[r].a1, vecs[r].a0};
            st_data = {vecs[r].d1, vecs[r].d0};
            tick();
            nm = $sformatf("vec%0d", r);
            chk({nm, "_state"}, 64'(dbg_state), 64'(vecs[r].e_state));
            chk({nm, "_err"}, 64'(err_cnt), 64'(vecs[r].e_err));
            chk({nm, "_cyc"}, 64'(cycle_cnt), 64'(vecs[r].e_cyc));
            chk({nm, "_ins"}, 64'(instr_cnt), 64'(vecs[r].e_cyc));
            chk({nm, "_pass"}, 64'(pass), 64'(vecs[r].e_pass));
            chk({nm, "_mmv"}, 64'(mm_valid), 64'(vecs[r].e_mmv));
        end
        clear_in();
        chk("vec_mm", {mm_addr, mm_data}, {32'h10, 32'hAB});

        // missing stores counted at finish
        do_reset();
        push_exp(32'h20, 32'h1); push_exp(32'h24, 32'h2); push_exp(32'h28, 32'h3);
        start = 1'b1; tick(); start = 1'b0;
        run_cyc(2'b01, 32'h20, 32'h1, 0, 0, 32'h4);
        run_cyc(2'b00, 0, 0, 0, 0, FIN);
        chk("missing_err", 64'(err_cnt), 64'd2);
        chk("missing_done_pass", {62'd0, done, pass}, {62'd0, 1'b1, 1'b0});

        // retire counting with stalls and a flush
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            pc = 32'(c * 4);
            stallD = (c == 2 || c == 3 || c == 5);
            flushD = (c == 8);
            tick();
        end
        stallD = 1'b0; flushD = 1'b0;
        chk("retire_cyc", 64'(cycle_cnt), 64'd10);
        chk("retire_ins", 64'(instr_cnt), 64'd6);

        // unexpected store on ch1, then another with empty FIFO
        do_reset();
        push_exp(32'h40, 32'h7);
        start = 1'b1; tick(); start = 1'b0;
        run_cyc(2'b11, 32'h40, 32'h7, 32'h44, 32'h9, 32'h4);
        chk("unexp_err", 64'(err_cnt), 64'd1);
        chk("unexp_mm", {mm_addr, mm_data}, {32'h44, 32'h9});
        run_cyc(2'b01, 32'h50, 32'h1, 0, 0, 32'h8);
        chk("unexp_err2", 64'(err_cnt), STOP ? 64'd1 : 64'd2);
        chk("unexp_mm_first", {31'd0, mm_valid, mm_addr}, {31'd0, 1'b1, 32'h44});

        // combinational halt
        do_reset();
        pc = FIN; #1;
        chk("halt_at_finish", 64'(cpu_halt), 64'd1);
        pc = 32'h4; #1;
        chk("halt_off", 64'(cpu_halt), 64'd0);

        // full FIFO, push blocked, push+pop in one cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_exp(32'(i * 4), 32'(32'h100 + i));
        chk("full_ready", 64'(exp_ready), 64'd0);
        exp_valid = 1'b1; exp_addr = 32'hBAD; exp_data = 32'h0;
        start = 1'b1; tick(); start = 1'b0;
        run_cyc(2'b01, 32'h0, 32'h100, 0, 0, 32'h4);
        exp_valid = 1'b0; #1;
        chk("after_pop_ready", 64'(exp_ready), 64'd1);
        exp_valid = 1'b1; exp_addr = 32'h1000; exp_data = 32'h55;
        run_cyc(2'b01, 32'h4, 32'h101, 0, 0, 32'h8);
        exp_valid = 1'b0;
        run_cyc(2'b00, 0, 0, 0, 0, FIN);
        chk("full_missing_err", 64'(err_cnt), 64'd63);
        chk("full_done", 64'(done), 64'd1);

        // asynchronous reset mid-run with FIFO half full
        do_reset();
        for (int i = 0; i < DEPTH / 2; i++) push_exp(32'(i * 4), 32'(i));
        start = 1'b1; tick(); start = 1'b0;
        run_cyc(2'b01, 32'h4, 32'h77, 0, 0, 32'h4);
        pc = 32'h8;
        #2 reset = 1'b0;
        #1 check_cleared("async_reset");
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_state", 64'(dbg_state), 64'd0);

        // randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000 && failures < 40; n++) begin
            int rank;
            rank = 0;
            start     = ($urandom_range(0, 9) == 0);
            pc        = ($urandom_range(0, 24) == 0) ? FIN : 32'($urandom_range(0, 255));
            stallD    = 1'($urandom_range(0, 1));
            flushD    = ($urandom_range(0, 3) == 0);
            exp_valid = 1'($urandom_range(0, 1));
            exp_addr  = 32'($urandom_range(0, 7) * 4);
            exp_data  = 32'($urandom_range(0, 3));
            for (int ch = 0; ch < NCH; ch++) begin
                st_valid[ch] = 1'($urandom_range(0, 1));
                st_addr[ch*AW +: AW] = 32'($urandom_range(0, 7) * 4);
                st_data[ch*DW +: DW] = 32'($urandom_range(0, 3));
                if (st_valid[ch]) begin
                    if (rank < m_q.size() && $urandom_range(0, 3) != 0) begin
                        st_addr[ch*AW +: AW] = m_q[rank][63:32];
                        st_data[ch*DW +: DW] = m_q[rank][31:0];
                    end
                    rank++;
                end
            end
            #1;
            chk("rnd_halt", 64'(cpu_halt), 64'((pc == FIN) || (m_state == 2)));
            chk("rnd_ready", 64'(exp_ready), 64'(m_q.size() < DEPTH));
            model_step();
            tick();
            chk("rnd_state", 64'(dbg_state), 64'(m_state));
            chk("rnd_err", 64'(err_cnt), 64'(m_err));
            chk("rnd_cyc", 64'(cycle_cnt), 64'(m_cyc));
            chk("rnd_ins", 64'(instr_cnt), 64'(m_ins));
            chk("rnd_done_pass", {62'd0, done, pass},
                {62'd0, 1'(m_state == 2), 1'(m_state == 2 && m_err == 0)});
            chk("rnd_mm", {31'd0, mm_valid, mm_addr, mm_data}, {31'd0, m_mmv, m_mma, m_mmd});
        end
        clear_in();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_trace_checker.md
PERF_TRACE_CHECKER -- requirements
Module: perf_trace_checker

Interface
REQ-001 SHALL have parameter NCH, default 2: number of store channels checked per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 64: expected-store FIFO entries (power of two, >= NCH).
REQ-003 SHALL have parameter AW, default 32: address/PC width.
REQ-004 SHALL have parameter DW, default 32: store data width.
REQ-005 SHALL have parameter CW, default 32: cycle/instruction counter width.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse beginning a run.
REQ-009 SHALL have port finish_pc  in  AW  PC value that ends the run.
REQ-010 SHALL have port pc  in  AW  CPU fetch PC.
REQ-011 SHALL have ports stallD, flushD  in  1 each  decode-stage stall/flush for retire counting.
REQ-012 SHALL have ports st_valid  in  NCH; st_addr  in  NCH*AW; st_data  in  NCH*DW: CPU store channels, channel 0 oldest.
REQ-013 SHALL have ports exp_valid  in  1; exp_ready  out  1; exp_addr  in  AW; exp_data  in  DW: expected-store load.
REQ-014 SHALL have ports cpu_halt, done, pass  out  1 each; cycle_cnt, instr_cnt  out  CW; err_cnt  out  16.
REQ-015 SHALL have ports mm_valid  out  1; mm_addr  out  AW; mm_data  out  DW: first mismatching actual store.

Function
REQ-016 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when pc == finish_pc; DONE -> RUN on start (counters, FIFO contents kept unless reset); start in RUN ignored.
REQ-017 SHALL assert cpu_halt combinationally when pc == finish_pc or state == DONE; stores with cpu_halt high are ignored.
REQ-018 SHALL increment cycle_cnt once per RUN cycle, instr_cnt per RUN cycle with ~stallD & ~flushD; both saturate at all-ones.
REQ-019 SHALL accept exp_* when exp_valid & exp_ready; exp_ready = ~full, in any state.
REQ-020 SHALL compare, each RUN cycle, valid channels in ascending index order against consecutive FIFO heads, popping one entry per valid channel in that cycle.
REQ-021 SHALL count an error when {addr,data} differs from its FIFO entry, or when the FIFO lacks an entry for a valid channel (unexpected store, nothing popped).
REQ-022 SHALL, on simultaneous push and pops in one cycle, update occupancy as count + push - pops with pointer wrap modulo DEPTH.
REQ-023 SHALL, on RUN -> DONE, add remaining FIFO occupancy (missing stores) to err_cnt and empty the FIFO in that single transition.
REQ-024 SHALL saturate err_cnt at 16'hFFFF; multiple errors in one cycle add their total.
REQ-025 SHALL latch mm_* and set mm_valid on the first mismatch/unexpected store only, lowest channel winning.
REQ-026 SHALL drive done = (state == DONE), pass = done & (err_cnt == 0).

Reset
REQ-027 SHALL, on reset low, immediately force IDLE, empty FIFO, all counters zero, mm_* zero, done/pass/mm_valid low, regardless of operation in progress.
REQ-028 SHALL release reset synchronously-safe: first state change no earlier than first rising clk after reset high.

Configuration
REQ-029 SHALL, with TRACE_STOP_ON_ERROR_EN defined, transition RUN -> DONE on the cycle of the first error, freezing counters and asserting cpu_halt.
REQ-030 SHALL, without TRACE_STOP_ON_ERROR_EN, count all errors and continue until finish_pc.

Structure
REQ-031 SHALL place state enum (IDLE, RUN, DONE) and error-count width constant in package perf_trace_pkg.
REQ-032 SHALL implement the expected-store store as sub-module trace_fifo (1 push, up to NCH pops per cycle, count output).

Verification
REQ-033 SHALL cover: load {0x0,0x5},{0x4,0x6}; ch0 stores both in successive cycles; finish_pc hit -> pass=1, err_cnt=0.
REQ-034 SHALL cover: NCH=2, both channels store {0x8,0x1},{0xC,0x2} same cycle, FIFO matches -> two pops, err_cnt=0.
REQ-035 SHALL cover: expected {0x10,0xAA}, actual {0x10,0xAB} -> err_cnt=1, mm_addr=0x10, mm_data=0xAB; with TRACE_STOP_ON_ERROR_EN done=1 same cycle.
REQ-036 SHALL cover: 3 entries loaded, 1 stored before finish_pc -> err_cnt=2, pass=0.
REQ-037 SHALL cover: 10 RUN cycles, stallD high 3, flushD high 1 -> cycle_cnt=10, instr_cnt=6.
REQ-038 SHALL cover: reset low mid-RUN with FIFO half full -> all outputs zero, state IDLE, exp_ready=1.
